// File: rtl/compare_skip_sequencer.sv
`default_nettype none
// ============================================================================
// compare_skip_sequencer: fetches one operand into DR, then samples AC==DR
// and pulses skip. Optional macro COMPARE_STATS_EN adds the match_cnt_o counter.
// Rev 1.0
// ============================================================================
module compare_skip_sequencer #(
  parameter int unsigned WIDTH   = 19,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 15
`ifdef COMPARE_STATS_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [WIDTH-1:0]  mem_rdata_i,
  output logic              dr_load_o,
  output logic [WIDTH-1:0]  dr_out_o,
  input  logic              eq_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              skip_o,
  output logic              timeout_err_o
`ifdef COMPARE_STATS_EN
  ,
  output logic [CNT_W-1:0]  match_cnt_o
`endif
);

  localparam int unsigned C_TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_LOAD = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q;
  logic                mem_req_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                dr_load_q;
  logic [WIDTH-1:0]    dr_out_q;
  logic                busy_q;
  logic                done_q;
  logic                skip_q;
  logic                timeout_q;
  logic [C_TO_W-1:0]   to_cnt_q;
  logic [C_TO_W-1:0]   to_cnt_d;
  logic                w_expire;

  assign to_cnt_d = to_cnt_q + C_TO_W'(1);
  // The wait cycle that brings the count to TIMEOUT is the last one allowed.
  assign w_expire = (TIMEOUT != 0) && (to_cnt_d == C_TO_W'(TIMEOUT));

`ifdef COMPARE_STATS_EN
  logic [CNT_W-1:0] match_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      dr_load_q   <= 1'b0;
      dr_out_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      skip_q      <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
`ifdef COMPARE_STATS_EN
      match_cnt_q <= '0;
`endif
    end else begin
      dr_load_q <= 1'b0;
      done_q    <= 1'b0;
      skip_q    <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_REQ;
            mem_addr_q <= addr_i;
            to_cnt_q   <= '0;
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        S_REQ: begin
          // A late ack in the expiry cycle still completes the read.
          if (mem_ack_i) begin
            state_q   <= S_LOAD;
            dr_out_q  <= mem_rdata_i;
            mem_req_q <= 1'b0;
            dr_load_q <= 1'b1;
          end else if (w_expire) begin
            state_q   <= S_DONE;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            to_cnt_q  <= to_cnt_d;
          end
        end
        S_LOAD: begin
          state_q <= S_CMP;
        end
        S_CMP: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          skip_q  <= eq_i;
`ifdef COMPARE_STATS_EN
          if (eq_i && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_q <= match_cnt_q + CNT_W'(1);
          end
`endif
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign dr_load_o     = dr_load_q;
  assign dr_out_o      = dr_out_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign skip_o        = skip_q;
  assign timeout_err_o = timeout_q;
`ifdef COMPARE_STATS_EN
  assign match_cnt_o   = match_cnt_q;
`endif

endmodule
`default_nettype wire
